// File: rtl/ofdm_pkg.sv
// Shared constants and FSM state types for the OFDM receiver FFT input path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ofdm_pkg;

  localparam int DEF_LOG2N  = 6;
  localparam int DEF_CP_LEN = 16;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_CP   = 2'd1,
    W_DATA = 2'd2
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_READ = 1'b1
  } rd_state_t;

endpackage

// File: rtl/bit_reverse.sv
// Reverses the bit order of a W-bit index (pure wiring).
// Latency: 0 cycles, combinational.
// Backpressure: none.
module bit_reverse #(
  parameter int W = 6
) (
  input  logic [W-1:0] i_dat,
  output logic [W-1:0] o_dat
);

  for (genvar g = 0; g < W; g++) begin : g_rev
    assign o_dat[g] = i_dat[W-1-g];
  end

endmodule

// File: rtl/pingpong_addr_gen.sv
// Ping-pong address generator: strips the CP, writes N-point symbols into alternating banks, reads the other bank toward the FFT.
// Latency: wr_en/wr_addr same cycle as the sample; first rd_en 2 cycles after a bank's last write; out_valid 1 cycle after rd_en.
// Backpressure: reads advance only on rd_ready; a symbol whose target bank is still full is dropped whole with an overflow pulse.
module pingpong_addr_gen
  import ofdm_pkg::*;
#(
  parameter int LOG2N     = DEF_LOG2N,
  parameter int CP_LEN    = DEF_CP_LEN,
  parameter bit BITREV_WR = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             sym_start,
  input  logic             rd_ready,
  output logic             wr_en,
  output logic             wr_bank,
  output logic [LOG2N-1:0] wr_addr,
  output logic             rd_en,
  output logic             rd_bank,
  output logic [LOG2N-1:0] rd_addr,
  output logic             out_valid,
  output logic             sym_done,
  output logic             overflow
);

  localparam int CPW = (CP_LEN > 0) ? $clog2(CP_LEN + 1) : 1;
  localparam logic [CPW-1:0]   CP_ONE   = CPW'(1);
  localparam logic [CPW-1:0]   CP_LAST  = CPW'(CP_LEN);
  localparam logic [LOG2N-1:0] CNT_ONE  = LOG2N'(1);
  localparam logic [LOG2N-1:0] CNT_LAST = '1;

  wr_state_t        r_wr_state;
  rd_state_t        r_rd_state;
  logic [CPW-1:0]   r_cp_cnt;
  logic [LOG2N-1:0] r_wr_cnt;
  logic [LOG2N-1:0] r_rd_cnt;
  logic [1:0]       r_full;
  logic             r_wr_bank;
  logic             r_rd_bank;
  logic             r_out_valid;
  logic             r_sym_done;
  logic             r_overflow;

  logic             w_start;
  logic             w_cp_sample;
  logic [CPW-1:0]   w_cp_nxt;
  logic             w_entry;
  logic             w_drop;
  logic [LOG2N-1:0] w_wr_idx;
  logic             w_wr_last;
  logic             w_rd_last;
  logic [1:0]       w_full_set;
  logic [1:0]       w_full_clr;
  logic [LOG2N-1:0] w_rev_in;
  logic [LOG2N-1:0] w_rev_out;

  // A qualified sym_start restarts the symbol from any write state.
  assign w_start     = in_valid && sym_start;
  // Samples that count toward the cyclic prefix (the sym_start sample is CP sample 0).
  assign w_cp_sample = (CP_LEN > 0) && (w_start || (in_valid && (r_wr_state == W_CP)));
  assign w_cp_nxt    = w_start ? CP_ONE : (r_cp_cnt + CP_ONE);
  // Entry into the data phase: the last CP sample, or the sym_start sample itself with no CP.
  assign w_entry     = (CP_LEN == 0) ? w_start : (w_cp_sample && (w_cp_nxt == CP_LAST));
  assign w_drop      = w_entry && r_full[r_wr_bank];

  assign wr_en     = (in_valid && !sym_start && (r_wr_state == W_DATA)) ||
                     ((CP_LEN == 0) && w_start && !w_drop);
  assign w_wr_idx  = w_start ? '0 : r_wr_cnt;
  assign w_wr_last = wr_en && (w_wr_idx == CNT_LAST);

  assign rd_en     = (r_rd_state == R_READ) && rd_ready;
  assign w_rd_last = rd_en && (r_rd_cnt == CNT_LAST);

  assign w_full_set = {w_wr_last &&  r_wr_bank, w_wr_last && !r_wr_bank};
  assign w_full_clr = {w_rd_last &&  r_rd_bank, w_rd_last && !r_rd_bank};

  // One reversal instance, placed on whichever side uses the scrambled order.
  assign w_rev_in = BITREV_WR ? w_wr_idx : r_rd_cnt;

  bit_reverse #(.W(LOG2N)) u_bit_reverse (
    .i_dat (w_rev_in),
    .o_dat (w_rev_out)
  );

  assign wr_addr   = BITREV_WR ? w_rev_out : w_wr_idx;
  assign rd_addr   = BITREV_WR ? r_rd_cnt  : w_rev_out;
  assign wr_bank   = r_wr_bank;
  assign rd_bank   = r_rd_bank;
  assign out_valid = r_out_valid;
  assign sym_done  = r_sym_done;
  assign overflow  = r_overflow;

  // Write FSM: CP skip, data-phase counting, bank toggle and overflow pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_state <= W_IDLE;
      r_cp_cnt   <= '0;
      r_wr_cnt   <= '0;
      r_wr_bank  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_drop;
      if (w_cp_sample) begin
        r_cp_cnt <= w_cp_nxt;
      end
      if (wr_en) begin
        r_wr_cnt <= w_wr_idx + CNT_ONE;
      end else if (w_start) begin
        r_wr_cnt <= '0;
      end
      if (w_wr_last) begin
        r_wr_bank  <= ~r_wr_bank;
        r_wr_state <= W_IDLE;
      end else if (w_entry) begin
        r_wr_state <= w_drop ? W_IDLE : W_DATA;
      end else if (w_start) begin
        r_wr_state <= W_CP;
      end
    end
  end

  // Full flags: set by the writer's last sample, cleared by the reader's last sample (always different banks).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 2'b00;
    end else begin
      r_full <= (r_full | w_full_set) & ~w_full_clr;
    end
  end

  // Read FSM: wait for the current read bank to fill, then stream it out under rd_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_state  <= R_IDLE;
      r_rd_cnt    <= '0;
      r_rd_bank   <= 1'b0;
      r_out_valid <= 1'b0;
      r_sym_done  <= 1'b0;
    end else begin
      r_out_valid <= rd_en;
      r_sym_done  <= w_rd_last;
      case (r_rd_state)
        R_IDLE: begin
          if (r_full[r_rd_bank]) begin
            r_rd_state <= R_READ;
          end
        end
        R_READ: begin
          if (rd_en) begin
            r_rd_cnt <= r_rd_cnt + CNT_ONE;
            if (w_rd_last) begin
              r_rd_state <= R_IDLE;
              r_rd_bank  <= ~r_rd_bank;
            end
          end
        end
        default: r_rd_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pingpong_addr_gen.sv
// Bench for pingpong_addr_gen: three configurations driven by directed vectors.
// A sample-position model predicts every output each cycle; literal checks pin key values.
// Inputs change 1 time unit after posedge; outputs are checked at posedge+2 and at negedge.
module tb_pingpong_addr_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] iv, ss, rr;
  logic [2:0] wen, wbk, ren, rbk, ovl, sdn, ovf;
  logic [5:0] wad0, rad0, wad2, rad2;
  logic [2:0] wad1, rad1;

  int n_tests = 0;
  int n_fail  = 0;

  int cfg_lg  [3] = '{6, 3, 6};
  int cfg_cp  [3] = '{16, 0, 16};
  int cfg_brw [3] = '{1, 1, 0};

  pingpong_addr_gen u_def (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .sym_start(ss[0]), .rd_ready(rr[0]),
    .wr_en(wen[0]), .wr_bank(wbk[0]), .wr_addr(wad0), .rd_en(ren[0]), .rd_bank(rbk[0]),
    .rd_addr(rad0), .out_valid(ovl[0]), .sym_done(sdn[0]), .overflow(ovf[0])
  );

  pingpong_addr_gen #(.LOG2N(3), .CP_LEN(0), .BITREV_WR(1'b1)) u_small (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .sym_start(ss[1]), .rd_ready(rr[1]),
    .wr_en(wen[1]), .wr_bank(wbk[1]), .wr_addr(wad1), .rd_en(ren[1]), .rd_bank(rbk[1]),
    .rd_addr(rad1), .out_valid(ovl[1]), .sym_done(sdn[1]), .overflow(ovf[1])
  );

  pingpong_addr_gen #(.LOG2N(6), .CP_LEN(16), .BITREV_WR(1'b0)) u_nat (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .sym_start(ss[2]), .rd_ready(rr[2]),
    .wr_en(wen[2]), .wr_bank(wbk[2]), .wr_addr(wad2), .rd_en(ren[2]), .rd_bank(rbk[2]),
    .rd_addr(rad2), .out_valid(ovl[2]), .sym_done(sdn[2]), .overflow(ovf[2])
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic mchk(input int d, input string nm, input int act, input int exp);
    chk($sformatf("dut%0d_%s", d, nm), act, exp);
  endtask

  function automatic int rev(input int v, input int w);
    int r = 0;
    for (int i = 0; i < w; i++) r |= ((v >> i) & 1) << (w - 1 - i);
    return r;
  endfunction

  function automatic int f_wad(input int d);
    case (d)
      0:       return int'(wad0);
      1:       return int'(wad1);
      default: return int'(wad2);
    endcase
  endfunction

  function automatic int f_rad(input int d);
    case (d)
      0:       return int'(rad0);
      1:       return int'(rad1);
      default: return int'(rad2);
    endcase
  endfunction

  // ---------------- behavioural model ----------------
  // m_pos: samples already consumed in the current symbol, -1 when no symbol is being accepted.
  int         m_pos     [3];
  logic [1:0] m_full    [3];
  bit         m_wb      [3];
  bit         m_rb      [3];
  bit         m_reading [3];
  int         m_rc      [3];
  bit         m_outv    [3];
  bit         m_sd      [3];
  bit         m_ov      [3];

  int c_n, c_p, c_entry, c_didx, c_ewad, c_erad;
  bit c_ewen, c_eren, c_nov, c_nsd, c_tw, c_tr;
  logic [1:0] c_f;

  task automatic m_clear(input int d);
    m_pos[d] = -1; m_full[d] = 2'b00; m_wb[d] = 0; m_rb[d] = 0;
    m_reading[d] = 0; m_rc[d] = 0; m_outv[d] = 0; m_sd[d] = 0; m_ov[d] = 0;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int d = 0; d < 3; d++) m_clear(d);
    end else begin
      for (int d = 0; d < 3; d++) begin
        c_n = 1 << cfg_lg[d];
        c_ewen = 0; c_ewad = 0; c_nov = 0; c_nsd = 0; c_tw = 0; c_tr = 0;
        c_f = m_full[d];
        c_p = -1;
        if (iv[d]) c_p = ss[d] ? 0 : m_pos[d];
        if (c_p >= 0) begin
          m_pos[d] = c_p + 1;
          c_entry = (cfg_cp[d] == 0) ? 0 : cfg_cp[d] - 1;
          if (c_p == c_entry && m_full[d][m_wb[d]]) begin
            c_nov = 1;
            m_pos[d] = -1;
          end else if (c_p >= cfg_cp[d]) begin
            c_didx = c_p - cfg_cp[d];
            c_ewen = 1;
            c_ewad = cfg_brw[d] ? rev(c_didx, cfg_lg[d]) : c_didx;
            if (c_didx == c_n - 1) begin
              c_f[m_wb[d]] = 1'b1;
              c_tw = 1;
              m_pos[d] = -1;
            end
          end
        end
        c_eren = m_reading[d] && rr[d];
        c_erad = cfg_brw[d] ? m_rc[d] : rev(m_rc[d], cfg_lg[d]);

        mchk(d, "wr_en", wen[d], c_ewen);
        if (c_ewen) mchk(d, "wr_addr", f_wad(d), c_ewad);
        mchk(d, "wr_bank", wbk[d], m_wb[d]);
        mchk(d, "rd_en", ren[d], c_eren);
        if (c_eren) mchk(d, "rd_addr", f_rad(d), c_erad);
        mchk(d, "rd_bank", rbk[d], m_rb[d]);
        mchk(d, "out_valid", ovl[d], m_outv[d]);
        mchk(d, "sym_done", sdn[d], m_sd[d]);
        mchk(d, "overflow", ovf[d], m_ov[d]);

        if (!m_reading[d]) begin
          if (m_full[d][m_rb[d]]) m_reading[d] = 1;
        end else if (rr[d]) begin
          if (m_rc[d] == c_n - 1) begin
            c_f[m_rb[d]] = 1'b0;
            c_tr = 1;
            m_reading[d] = 0;
            m_rc[d] = 0;
            c_nsd = 1;
          end else begin
            m_rc[d]++;
          end
        end
        m_full[d] = c_f;
        m_outv[d] = c_eren;
        m_sd[d]   = c_nsd;
        m_ov[d]   = c_nov;
        if (c_tw) m_wb[d] = !m_wb[d];
        if (c_tr) m_rb[d] = !m_rb[d];
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input int d, input bit v, input bit s, input bit r);
    @(posedge clk);
    #1;
    iv[d] = v; ss[d] = s; rr[d] = r;
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    iv = '0; ss = '0; rr = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ea[5];
    int eb[8];
    int er[3];
    int ovc, wc, rc;
    bit done;
    int q_w[$];
    int q_r[$];

    ea = '{0, 32, 16, 48, 8};
    eb = '{0, 4, 2, 6, 1, 5, 3, 7};
    er = '{0, 32, 16};

    rst_n = 1'b0;
    iv = '0; ss = '0; rr = '0;
    #2;
    for (int d = 0; d < 3; d++) begin
      mchk(d, "rst_wr_en", wen[d], 0);
      mchk(d, "rst_wr_bank", wbk[d], 0);
      mchk(d, "rst_rd_bank", rbk[d], 0);
      mchk(d, "rst_out_valid", ovl[d], 0);
      mchk(d, "rst_overflow", ovf[d], 0);
    end
    chk("rst_wr_addr0", wad0, 0);
    chk("rst_rd_addr0", rad0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // A: defaults, one symbol of 80 contiguous samples, reader always ready.
    for (int k = 0; k < 80; k++) begin
      drive(0, 1'b1, k == 0, 1'b1);
      if (k == 15) chk("A_last_cp_not_written", wen[0], 0);
      if (k == 16) chk("A_first_write", wen[0], 1);
      if (k >= 16 && k <= 20) chk("A_wr_addr_bitrev", wad0, ea[k-16]);
      if (k == 79) begin
        chk("A_last_wr_addr", wad0, 63);
        chk("A_wr_bank0", wbk[0], 0);
      end
    end
    drive(0, 1'b0, 1'b0, 1'b1);
    chk("A_no_read_1cyc_after", ren[0], 0);
    drive(0, 1'b0, 1'b0, 1'b1);
    chk("A_read_2cyc_after", ren[0], 1);
    chk("A_rd_addr_first", rad0, 0);
    for (int j = 1; j < 64; j++) begin
      drive(0, 1'b0, 1'b0, 1'b1);
      if (j == 1) chk("A_out_valid_trails", ovl[0], 1);
      if (j == 63) chk("A_rd_addr_last", rad0, 63);
    end
    drive(0, 1'b0, 1'b0, 1'b1);
    chk("A_sym_done_pulse", sdn[0], 1);
    drive(0, 1'b0, 1'b0, 1'b1);
    chk("A_sym_done_single", sdn[0], 0);

    // B: LOG2N=3, CP_LEN=0, four symbols with short gaps, reader always ready.
    do_reset();
    ovc = 0;
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 8; k++) begin
        drive(1, 1'b1, k == 0, 1'b1);
        ovc += int'(ovf[1]);
        if (s == 0) chk("B_wr_addr_bitrev", wad1, eb[k]);
        if (k == 0) chk("B_bank_alternates", wbk[1], s % 2);
      end
      repeat (2) begin
        drive(1, 1'b0, 1'b0, 1'b1);
        ovc += int'(ovf[1]);
      end
    end
    repeat (30) begin
      drive(1, 1'b0, 1'b0, 1'b1);
      ovc += int'(ovf[1]);
    end
    chk("B_no_overflow", ovc, 0);

    // C: reader stalled, three symbols; third is dropped.
    do_reset();
    ovc = 0; wc = 0; rc = 0;
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 80; k++) begin
        drive(0, 1'b1, k == 0, 1'b0);
        rc += int'(ren[0]);
        if (s == 2) begin
          ovc += int'(ovf[0]);
          wc  += int'(wen[0]);
          if (k == 16) chk("C_overflow_after_cp", ovf[0], 1);
        end
      end
      drive(0, 1'b0, 1'b0, 1'b0);
      if (s == 2) ovc += int'(ovf[0]);
    end
    drive(0, 1'b0, 1'b0, 1'b0);
    ovc += int'(ovf[0]);
    chk("C_one_overflow", ovc, 1);
    chk("C_no_write_dropped", wc, 0);
    chk("C_wr_bank_stays0", wbk[0], 0);
    chk("C_no_reads", rc, 0);

    // D: resync at write index 20.
    do_reset();
    rc = 0;
    for (int k = 0; k < 36; k++) begin
      drive(0, 1'b1, k == 0, 1'b1);
      rc += int'(ren[0]);
    end
    drive(0, 1'b1, 1'b1, 1'b1);
    chk("D_resync_sample_is_cp", wen[0], 0);
    rc += int'(ren[0]);
    for (int k = 1; k < 80; k++) begin
      drive(0, 1'b1, 1'b0, 1'b1);
      rc += int'(ren[0]);
      if (k == 16) begin
        chk("D_restart_first_write", wen[0], 1);
        chk("D_restart_addr0", wad0, 0);
        chk("D_restart_bank0", wbk[0], 0);
      end
    end
    chk("D_no_read_before_complete", rc, 0);
    drive(0, 1'b0, 1'b0, 1'b1);
    drive(0, 1'b0, 1'b0, 1'b1);
    chk("D_read_after_complete", ren[0], 1);
    repeat (70) drive(0, 1'b0, 1'b0, 1'b1);

    // E: BITREV_WR=0, in_valid every other cycle, rd_ready 2 of 3 cycles.
    do_reset();
    done = 0;
    q_w.delete();
    q_r.delete();
    for (int c = 0; c < 400 && !done; c++) begin
      drive(2, (c < 160) && (c % 2 == 0), c == 0, (c % 3) != 2);
      if (wen[2] && q_w.size() < 3) q_w.push_back(int'(wad2));
      if (ren[2] && q_r.size() < 3) q_r.push_back(int'(rad2));
      if (c == 33) chk("E_gap_no_write", wen[2], 0);
      if (sdn[2]) done = 1;
    end
    chk("E_sym_done_seen", done, 1);
    for (int i = 0; i < 3; i++) begin
      chk("E_wr_addr_natural", (q_w.size() > i) ? q_w[i] : -1, i);
      chk("E_rd_addr_bitrev", (q_r.size() > i) ? q_r[i] : -1, er[i]);
    end

    // F: asynchronous reset in the middle of a read.
    do_reset();
    for (int k = 0; k < 80; k++) drive(0, 1'b1, k == 0, 1'b1);
    repeat (10) drive(0, 1'b0, 1'b0, 1'b1);
    chk("F_reading_before_reset", ren[0], 1);
    chk("F_wr_bank_toggled", wbk[0], 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("F_rst_wr_en", wen[0], 0);
    chk("F_rst_wr_bank", wbk[0], 0);
    chk("F_rst_wr_addr", wad0, 0);
    chk("F_rst_rd_en", ren[0], 0);
    chk("F_rst_rd_bank", rbk[0], 0);
    chk("F_rst_rd_addr", rad0, 0);
    chk("F_rst_out_valid", ovl[0], 0);
    chk("F_rst_sym_done", sdn[0], 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 17; k++) begin
      drive(0, 1'b1, k == 0, 1'b1);
      if (k == 16) begin
        chk("F_post_reset_write", wen[0], 1);
        chk("F_post_reset_bank0", wbk[0], 0);
      end
    end
    drive(0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
